counter_mod_k_ro_core: RTL and testbench



---
 rtl/counter_mod_k_ro_core_if.sv | 27 ++
 rtl/counter_mod_k_ro_core.sv | 49 ++++
 tb/tb_counter_mod_k_ro_core.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_mod_k_ro_core_if.sv
// -----------------------------------------------------------------------------
// counter_mod_k_ro_core_if
// Bundles the modulus input and the roll-over pulse of counter_mod_k_ro_core.
//   i_k          [N-1:0]  modulus k, driven by the master (count runs 0..k-1)
//   o_roll_over           registered one-cycle pulse, driven by the counter
// Modports:
//   master : drives i_k, observes o_roll_over (the user of the counter)
//   slave  : receives i_k, drives o_roll_over (the counter itself)
// There is no valid/ready handshake: i_k is a level sampled on every rising
// clock edge, and o_roll_over is a level that is valid for a whole cycle.
// -----------------------------------------------------------------------------
interface counter_mod_k_ro_core_if #(
   parameter int N = 2
);
   logic [N-1:0] i_k;
   logic         o_roll_over;

   modport master (
      output i_k,
      input  o_roll_over
   );

   modport slave (
      input  i_k,
      output o_roll_over
   );
endinterface

// File: rtl/counter_mod_k_ro_core.sv
// -----------------------------------------------------------------------------
// counter_mod_k_ro_core
// Synchronous modulo-k up-counter with a runtime-programmable modulus. Emits a
// registered one-cycle roll-over pulse each time the count wraps from k-1 to 0,
// so the pulse repeats every k clock cycles (every 2^N cycles when k=0, every
// cycle when k=1).
// Ports:
//   i_clk     clock; all state updates on its rising edge
//   i_reset   synchronous, active-high reset (count and pulse cleared)
//   bus       slave side of counter_mod_k_ro_core_if
//               bus.i_k          modulus k (unsigned, N bits)
//               bus.o_roll_over  registered roll-over pulse
// -----------------------------------------------------------------------------
module counter_mod_k_ro_core #(
   parameter int N = 2
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   counter_mod_k_ro_core_if.slave   bus
);

   logic [N-1:0] count;
   logic         ro_q;
   logic [N-1:0] k_minus_1;
   logic         wrap;

   // k-1 is taken modulo 2^N: k=0 becomes all-ones, giving a 2^N period.
   assign k_minus_1 = bus.i_k - N'(1);

   // Using >= rather than == means a modulus lowered below the current count
   // wraps on the next edge instead of running on through the overflow range.
   assign wrap = (count >= k_minus_1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count <= '0;
         ro_q  <= 1'b0;
      end else if (wrap) begin
         count <= '0;
         ro_q  <= 1'b1;
      end else begin
         count <= count + N'(1);
         ro_q  <= 1'b0;
      end
   end

   assign bus.o_roll_over = ro_q;

endmodule

// File: tb/tb_counter_mod_k_ro_core.sv
// -----------------------------------------------------------------------------
// tb_counter_mod_k_ro_core
// Directed bench for counter_mod_k_ro_core. Two instances share the clock:
// dut_a with N=2 and dut_b with N=4. Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_counter_mod_k_ro_core;

   logic clk;
   logic rst_a;
   logic rst_b;

   int   n_checks;
   int   n_fail;

   counter_mod_k_ro_core_if #(.N(2)) bus_a ();
   counter_mod_k_ro_core_if #(.N(4)) bus_b ();

   counter_mod_k_ro_core #(.N(2)) dut_a (
      .i_clk   (clk),
      .i_reset (rst_a),
      .bus     (bus_a.slave)
   );

   counter_mod_k_ro_core #(.N(4)) dut_b (
      .i_clk   (clk),
      .i_reset (rst_b),
      .bus     (bus_b.slave)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed,
                  expected, $time);
      end
   endtask

   // ---------------- drivers ----------------
   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ro(input bit use_b);
      return use_b ? bus_b.o_roll_over : bus_a.o_roll_over;
   endfunction

   // Apply one reset edge with modulus k, check the pulse is low afterwards,
   // and leave reset released.
   task automatic reset_with_k(input bit use_b, input int k, input string tag);
      if (use_b) begin
         bus_b.i_k = 4'(k);
         rst_b     = 1'b1;
      end else begin
         bus_a.i_k = 2'(k);
         rst_a     = 1'b1;
      end
      tick();
      check({tag, "_after_reset"}, 32'(ro(use_b)), 32'd0);
      if (use_b) rst_b = 1'b0;
      else       rst_a = 1'b0;
   endtask

   // Expect `reps` periods of length p: low for p-1 edges then high for one.
   task automatic expect_period(input bit use_b, input int p, input int reps,
                                input string tag);
      for (int r = 0; r < reps; r++) begin
         for (int e = 1; e <= p; e++) begin
            tick();
            check($sformatf("%s_r%0d_e%0d", tag, r, e), 32'(ro(use_b)),
                  (e == p) ? 32'd1 : 32'd0);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_a     = 1'b1;
      rst_b     = 1'b1;
      bus_a.i_k = 2'd3;
      bus_b.i_k = 4'd10;
      #1;

      // 1. k=3: reset edge, then 0,0,1 repeating for 5 periods.
      reset_with_k(1'b0, 3, "k3");
      expect_period(1'b0, 3, 5, "k3");

      // 2. k=0 -> modulo 4 on a 2-bit counter; k=2 -> alternating.
      reset_with_k(1'b0, 0, "k0");
      expect_period(1'b0, 4, 3, "k0");
      reset_with_k(1'b0, 2, "k2");
      expect_period(1'b0, 2, 4, "k2");

      // 3. k=1: low right after reset, then high every cycle.
      reset_with_k(1'b0, 1, "k1");
      expect_period(1'b0, 1, 6, "k1");

      // 4. k=3, reset when count=1: pulse stays low, full period follows.
      reset_with_k(1'b0, 3, "midrst");
      tick();
      check("midrst_count1", 32'(ro(1'b0)), 32'd0);
      rst_a = 1'b1;
      tick();
      check("midrst_reset_edge", 32'(ro(1'b0)), 32'd0);
      rst_a = 1'b0;
      expect_period(1'b0, 3, 2, "midrst");

      // 5. k=3 with count=2, switch to k=2: immediate wrap, then period 2.
      reset_with_k(1'b0, 3, "chg");
      tick();
      check("chg_count1", 32'(ro(1'b0)), 32'd0);
      tick();
      check("chg_count2", 32'(ro(1'b0)), 32'd0);
      bus_a.i_k = 2'd2;
      tick();
      check("chg_wrap_now", 32'(ro(1'b0)), 32'd1);
      expect_period(1'b0, 2, 3, "chg_k2");

      // Raising k on the fly does not cause an early pulse: count is 0 here.
      bus_a.i_k = 2'd0;
      expect_period(1'b0, 4, 2, "chg_k0");

      // 6. N=4, k=10: single-cycle pulse every 10 cycles.
      reset_with_k(1'b1, 10, "n4k10");
      expect_period(1'b1, 10, 3, "n4k10");

      // N=4, k=0 -> modulo 16.
      reset_with_k(1'b1, 0, "n4k0");
      expect_period(1'b1, 16, 2, "n4k0");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
